regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback requesters: ALU result and LSU load return.
//  Two-way round-robin arbitration with valid/ready handshakes; winning write presented to the register file one cycle later (registered).
//  Holds a 32-entry pending-write scoreboard (set at issue, cleared at commit) so decode can stall on RAW hazards.
//  Sits between execute/memory stages and Register_File (drives write_flag, write_a_select, write_a).
// PARAMETERS
//  XLEN        32  data width of write port and requester data
//  NREG        32  number of architectural registers (x0..x31)
//  REG_ADDR_W  5   register index width, = $clog2(NREG)
// PORTS
//  clk             in   1           clock, all state on rising edge
//  reset           in   1           asynchronous, active-low reset (0 = in reset)
//  alu_valid       in   1           ALU has a result to write
//  alu_rd          in   REG_ADDR_W  ALU destination register
//  alu_data        in   XLEN        ALU result
//  alu_ready       out  1           ALU write accepted this cycle
//  ld_valid        in   1           LSU has load data to write
//  ld_rd           in   REG_ADDR_W  load destination register
//  ld_data         in   XLEN        load data
//  ld_ready        out  1           load write accepted this cycle
//  iss_valid       in   1           an instruction with a destination issues this cycle
//  iss_rd          in   REG_ADDR_W  its destination register
//  rs1_sel         in   REG_ADDR_W  decode source 1 index
//  rs2_sel         in   REG_ADDR_W  decode source 2 index
//  rs1_busy        out  1           pending write outstanding on rs1_sel
//  rs2_busy        out  1           pending write outstanding on rs2_sel
//  write_flag      out  1           register file write enable
//  write_a_select  out  REG_ADDR_W  register file write index
//  write_a         out  XLEN        register file write data
// BEHAVIOUR
//  Reset (reset==0, async): write_flag=0, write_a_select=0, write_a=0, pending=0, last_grant=LD (ALU wins first tie); alu_ready=ld_ready=0 while in reset.
//  Handshake: transfer when valid && ready; requester holds valid/rd/data stable until ready. ready is combinational from valids and last_grant; never asserted without own valid.
//  Arbitration: one valid -> that requester granted. Both valid -> requester not in last_grant granted; last_grant updates only on a transfer.
//  Exactly one transfer per cycle max; the loser sees ready=0 and retries next cycle.
//  Latency: transfer in cycle N -> write_flag=1 with registered rd/data in cycle N+1; write_flag=0 in every cycle following no transfer.
//  rd==0: transfer still accepted (ready=1), last_grant updates, but write_flag stays 0 in N+1 (x0 never written).
//  Scoreboard: 32-bit pending vector, bit 0 tied 0.
//   set: iss_valid && iss_rd!=0 -> pending[iss_rd]<=1 at clock edge.
//   clear: write_flag==1 (commit cycle) -> pending[write_a_select]<=0 at clock edge.
//   same index set and clear same edge -> set wins (newer producer outstanding).
//  rsN_busy = pending[rsN_sel] (combinational, registered state only); rsN_sel==0 -> busy=0.
//  Same rd from both requesters in same cycle: serialized in grant order; last committed value is the final register value.
//  Reset mid-operation: registered write in flight is dropped (write_flag forced 0), pending cleared, no partial write.
// STRUCTURE
//  Shared package rv32_pkg: XLEN, NREG, REG_ADDR_W constants; wb_src_t enum {WB_ALU, WB_LD} for last_grant.
//  Sub-module rr_arbiter2: 2-way round-robin (req[1:0], grant[1:0], last-grant state, update on accept).
//  Top holds output register stage, rd==0 filter, and pending scoreboard.
// TESTING
//  1 Reset: drive reset=0 mid-stream with write_flag=1 -> all outputs 0 immediately, pending==0, readys 0.
//  2 Single ALU: alu_valid=1 rd=5 data=0xDEADBEEF cycle N -> alu_ready=1 in N; write_flag=1 sel=5 data=0xDEADBEEF in N+1 only.
//  3 Contention: both valid, ALU rd=3 0x11, LD rd=4 0x22 held -> N: ALU granted; N+1: LD granted, write x3; N+2: write x4; further ties alternate.
//  4 x0 drop: ld_valid rd=0 data=0x55 -> ld_ready=1, write_flag stays 0 next cycle, pending unchanged.
//  5 Scoreboard: iss_valid rd=7 -> rs1_sel=7 busy=1 next cycle; ALU write rd=7 commits -> busy=0 cycle after commit; set+clear rd=7 same edge -> busy stays 1.
//  6 Starvation: ALU valid every cycle, LD valid held -> LD granted within 2 cycles, never starved.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 core constants and the writeback source encoding used by the
// register-file write-port arbiter.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Request/grant bit 0 is the ALU and bit 1 is
// the LSU. The last winner loses the next tie.
module rr_arbiter2
    import rv32_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    wb_src_t    r_last;
    logic [1:0] w_grant;

    // Grant selection from the current requests and the previous winner
    always_comb begin
        w_grant = 2'b00;
        case (i_req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11: begin
                if (r_last == WB_LD) begin
                    w_grant = 2'b01;
                end else begin
                    w_grant = 2'b10;
                end
            end
            default: w_grant = 2'b00;
        endcase
    end

    // Remember the winner; every grant is a transfer because ready follows grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= WB_LD;
        end else if (w_grant[0]) begin
            r_last <= WB_ALU;
        end else if (w_grant[1]) begin
            r_last <= WB_LD;
        end else begin
            r_last <= r_last;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and LSU writeback, with a
// registered write stage and a pending-write scoreboard for RAW hazard stalls.
module regfile_wb_arbiter
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] rs1_sel,
    input  logic [REG_ADDR_W-1:0] rs2_sel,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  write_flag,
    output logic [REG_ADDR_W-1:0] write_a_select,
    output logic [XLEN-1:0]       write_a
);

    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_wr_rd;
    logic [XLEN-1:0]       w_wr_data;
    logic [NREG-1:0]       w_pending_nxt;

    logic                  r_write_flag;
    logic [REG_ADDR_W-1:0] r_write_sel;
    logic [XLEN-1:0]       r_write_data;
    logic [NREG-1:0]       r_pending;

    // Requests are masked while reset is held so neither ready can rise
    assign w_req = {ld_valid, alu_valid} & {2{reset}};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign alu_ready = w_grant[0];
    assign ld_ready  = w_grant[1];
    assign w_xfer    = w_grant[0] | w_grant[1];

    // Select the winning requester's destination and data
    always_comb begin
        w_wr_rd   = {REG_ADDR_W{1'b0}};
        w_wr_data = {XLEN{1'b0}};
        case (w_grant)
            2'b01: begin
                w_wr_rd   = alu_rd;
                w_wr_data = alu_data;
            end
            2'b10: begin
                w_wr_rd   = ld_rd;
                w_wr_data = ld_data;
            end
            default: begin
                w_wr_rd   = {REG_ADDR_W{1'b0}};
                w_wr_data = {XLEN{1'b0}};
            end
        endcase
    end

    // Output register stage; an x0 destination is accepted but never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_flag <= 1'b0;
            r_write_sel  <= {REG_ADDR_W{1'b0}};
            r_write_data <= {XLEN{1'b0}};
        end else if (w_xfer) begin
            r_write_flag <= (w_wr_rd != {REG_ADDR_W{1'b0}});
            r_write_sel  <= w_wr_rd;
            r_write_data <= w_wr_data;
        end else begin
            r_write_flag <= 1'b0;
            r_write_sel  <= r_write_sel;
            r_write_data <= r_write_data;
        end
    end

    // Scoreboard next state; the issue set is applied last so it beats a same-index commit
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_write_flag) begin
            w_pending_nxt[r_write_sel] = 1'b0;
        end else begin
            w_pending_nxt = r_pending;
        end
        if (iss_valid && (iss_rd != {REG_ADDR_W{1'b0}})) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end else begin
            w_pending_nxt[0] = 1'b0;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Pending-write scoreboard state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= {NREG{1'b0}};
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign rs1_busy = (rs1_sel != {REG_ADDR_W{1'b0}}) ? r_pending[rs1_sel] : 1'b0;
    assign rs2_busy = (rs2_sel != {REG_ADDR_W{1'b0}}) ? r_pending[rs2_sel] : 1'b0;

    assign write_flag     = r_write_flag;
    assign write_a_select = r_write_sel;
    assign write_a        = r_write_data;

endmodule
